// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 sizes,
// the load result-source code, FSM states and legality helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        if (f3[1:0] == 2'b01)
            bad = off[0];
        else if (f3[1:0] == 2'b10)
            bad = (off != 2'b00);
        else
            bad = 1'b0;
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load's funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: req/ready handshake to data memory, pipeline
// stall while an access is outstanding, store lane alignment, load extension.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        funct3M,
    output logic              StallM,
    output logic [31:0]       ReadDataM,
    output logic              MisalignM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic              r_mis;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;

    logic              w_store;
    logic              w_load;
    logic              w_access;
    logic              w_bad;
    logic              w_legal;
    logic              w_idle;
    logic [1:0]        w_off;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ext;

    assign w_off    = ALUResultM[1:0];
    assign w_store  = MemWriteM;
    assign w_load   = !MemWriteM && (ResultSrcM == RESULTSRC_LOAD);
    assign w_access = w_store || w_load;
    assign w_bad    = w_access && (!f3_legal(w_store, funct3M) || misaligned(funct3M, w_off));
    assign w_legal  = w_access && !w_bad;
    assign w_idle   = (r_state == IDLE);

    // Narrow stores are replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        w_wdata = WriteDataM;
        w_wstrb = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                w_wdata = {4{WriteDataM[7:0]}};
                w_wstrb = 4'b0001 << w_off;
            end
            2'b01: begin
                w_wdata = {2{WriteDataM[15:0]}};
                w_wstrb = 4'b0011 << w_off;
            end
            default: ;
        endcase
        if (!w_store)
            w_wstrb = 4'b0000;
    end

    load_extend u_load_extend (
        .i_rdata  (mem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_mis    <= 1'b0;
            r_wstrb  <= 4'b0000;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_offset <= 2'd0;
        end else begin
            r_mis <= w_idle && w_bad;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state  <= BUSY;
                        r_req    <= 1'b1;
                        r_we     <= w_store;
                        r_addr   <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_wstrb  <= w_wstrb;
                        r_funct3 <= funct3M;
                        r_offset <= w_off;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'b0000;
                        if (!r_we)
                            r_rdata <= w_ext;
                    end
                end
                // DONE: the instruction is still in M this cycle, so it must not restart.
                default: r_state <= IDLE;
            endcase
        end
    end

    assign StallM    = (w_idle && w_legal) || (r_state == BUSY);
    assign ReadDataM = r_rdata;
    assign MisalignM = r_mis;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, random
// transactions against a behavioural model, back-to-back and reset-in-BUSY cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd;

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        int          e_stall;
        logic        e_mis;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                                input logic [31:0] rdata, input logic [31:0] e_addr,
                                input logic [3:0] e_strb, input logic [31:0] e_wdata,
                                input logic [31:0] e_rd, input int e_stall, input logic e_mis);
        vec_t v;
        v.we = we; v.rs = rs; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.rdata = rdata; v.e_addr = e_addr; v.e_strb = e_strb;
        v.e_wdata = e_wdata; v.e_rd = e_rd; v.e_stall = e_stall; v.e_mis = e_mis;
        return v;
    endfunction

    // 0 = no access, 1 = legal access, 2 = illegal or misaligned
    function automatic int classify(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                                    input logic [31:0] a);
        bit ld;
        bit ok;
        int size;
        ld = !we && (rs == 2'b01);
        if (!we && !ld) return 0;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!ok) return 2;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 2;
        return 1;
    endfunction

    function automatic void store_model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d, output logic [3:0] s,
                                        output logic [31:0] w);
        int n;
        int off;
        logic [7:0] m;
        n   = 1 << f3[1:0];
        off = int'(a % 4);
        m   = 8'((1 << n) - 1);
        m   = m << off;
        s   = m[3:0];
        if (n == 1)      w = 32'(d[7:0]) * 32'h01010101;
        else if (n == 2) w = 32'(d[15:0]) * 32'h00010001;
        else             w = d;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        longint n;
        longint v;
        n = longint'(1) << f3[1:0];
        v = longint'(rd) >> (8 * (a % 4));
        v = v & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        mem_ready  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the unit idle again.
    task automatic run_txn(input vec_t v, input string tag);
        int stalls;
        int nreq;
        int nmis;
        bit left;
        stalls = 0; nreq = 0; nmis = 0; left = 0;
        MemWriteM  = v.we;
        ResultSrcM = v.rs;
        funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wdata;
        mem_rdata  = v.rdata;
        mem_ready  = 1'b0;
        for (int cyc = 0; cyc < 40 && !left; cyc++) begin
            #1;
            if (MisalignM) nmis++;
            if (mem_req) begin
                chk({tag, " mem_addr"}, mem_addr, v.e_addr);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
                chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.e_strb));
                if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
                mem_ready = (nreq == v.waits);
                nreq++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (StallM) stalls++;
            else begin
                left = 1;
                chk({tag, " ReadDataM"}, ReadDataM, v.e_rd);
            end
            @(posedge clk);
            #1;
        end
        if (!left) begin
            checks++;
            errors++;
            $display("FAIL %s timeout stall_cycles=%0d required=%0d", tag, stalls, v.e_stall);
        end
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
        chk({tag, " req_cycles"}, 32'(nreq), 32'((v.e_stall > 0) ? v.waits + 1 : 0));
        drive_idle();
        #1;
        if (MisalignM) nmis++;
        chk({tag, " MisalignM_after"}, 32'(MisalignM), 32'(v.e_mis));
        chk({tag, " mem_req_after"}, 32'(mem_req), 32'd0);
        chk({tag, " misalign_pulses"}, 32'(nmis), 32'(v.e_mis));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        mem_rdata = 32'd0;
        drive_idle();

        //           we    rs     f3    addr          wdata         w  rdata         e_addr        strb     e_wdata       e_rd          st mis
        tbl[0]  = mk(1'b1, 2'b00, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0,        32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        2, 1'b0);
        tbl[1]  = mk(1'b1, 2'b00, 3'd0, 32'h203, 32'h000000A5, 1, 32'h0,        32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0,        3, 1'b0);
        tbl[2]  = mk(1'b0, 2'b01, 3'd0, 32'h101, 32'h0,        0, 32'h123480FF, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 2, 1'b0);
        tbl[3]  = mk(1'b0, 2'b01, 3'd4, 32'h101, 32'h0,        0, 32'h123480FF, 32'h100, 4'b0000, 32'h0,        32'h00000080, 2, 1'b0);
        tbl[4]  = mk(1'b0, 2'b01, 3'd1, 32'h102, 32'h0,        3, 32'h80010000, 32'h100, 4'b0000, 32'h0,        32'hFFFF8001, 5, 1'b0);
        tbl[5]  = mk(1'b0, 2'b01, 3'd2, 32'h102, 32'h0,        0, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFF8001, 0, 1'b1);
        tbl[6]  = mk(1'b1, 2'b00, 3'd1, 32'h102, 32'h1234ABCD, 0, 32'h0,        32'h100, 4'b1100, 32'hABCDABCD, 32'hFFFF8001, 2, 1'b0);
        tbl[7]  = mk(1'b0, 2'b01, 3'd5, 32'h100, 32'h0,        2, 32'h1234F00D, 32'h100, 4'b0000, 32'h0,        32'h0000F00D, 4, 1'b0);
        tbl[8]  = mk(1'b0, 2'b01, 3'd2, 32'h104, 32'h0,        0, 32'hCAFEF00D, 32'h104, 4'b0000, 32'h0,        32'hCAFEF00D, 2, 1'b0);
        tbl[9]  = mk(1'b1, 2'b00, 3'd4, 32'h100, 32'h11,       0, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hCAFEF00D, 0, 1'b1);
        tbl[10] = mk(1'b0, 2'b01, 3'd3, 32'h100, 32'h0,        0, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hCAFEF00D, 0, 1'b1);
        tbl[11] = mk(1'b1, 2'b00, 3'd1, 32'h101, 32'h5555,     0, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hCAFEF00D, 0, 1'b1);
        tbl[12] = mk(1'b0, 2'b00, 3'd2, 32'h100, 32'h0,        0, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hCAFEF00D, 0, 1'b0);
        tbl[13] = mk(1'b1, 2'b01, 3'd2, 32'h108, 32'h0BADF00D, 0, 32'h0,        32'h108, 4'b1111, 32'h0BADF00D, 32'hCAFEF00D, 2, 1'b0);
        tbl[14] = mk(1'b0, 2'b01, 3'd0, 32'h103, 32'h0,        1, 32'h7F000000, 32'h100, 4'b0000, 32'h0,        32'h0000007F, 3, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("reset MisalignM", 32'(MisalignM), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset ReadDataM", ReadDataM, 32'd0);
        chk("reset StallM", 32'(StallM), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));
        exp_rd = tbl[14].e_rd;

        for (int n = 0; n < 150; n++) begin
            vec_t v;
            int cls;
            v.we    = ($urandom_range(0, 2) == 0);
            v.rs    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.waits = $urandom_range(0, 3);
            cls     = classify(v.we, v.rs, v.f3, v.addr);
            v.e_addr  = (v.addr / 4) * 4;
            v.e_strb  = 4'b0000;
            v.e_wdata = 32'd0;
            if (cls == 1 && v.we)  store_model(v.f3, v.addr, v.wdata, v.e_strb, v.e_wdata);
            if (cls == 1 && !v.we) exp_rd = load_model(v.f3, v.addr, v.rdata);
            v.e_rd    = exp_rd;
            v.e_stall = (cls == 1) ? 2 + v.waits : 0;
            v.e_mis   = (cls == 2);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        // Back-to-back: second access presented in the IDLE cycle after DONE.
        begin
            int a_req;
            int b_req;
            int phase;
            bit leaving;
            a_req = -1; b_req = -1; phase = 0;
            MemWriteM = 1'b1; ResultSrcM = 2'b00; funct3M = 3'd2;
            ALUResultM = 32'h80; WriteDataM = 32'h00000001;
            mem_rdata = 32'h5555AAAA; mem_ready = 1'b0;
            for (int cyc = 0; cyc < 20 && phase < 2; cyc++) begin
                #1;
                if (mem_req) begin
                    mem_ready = 1'b1;
                    if (phase == 0 && a_req < 0) a_req = cyc;
                    if (phase == 1 && b_req < 0) b_req = cyc;
                end else begin
                    mem_ready = 1'b0;
                end
                leaving = !StallM;
                if (leaving && phase == 1) chk("b2b ReadDataM", ReadDataM, 32'h5555AAAA);
                @(posedge clk);
                #1;
                if (leaving) begin
                    phase++;
                    if (phase == 1) begin
                        MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'd2; ALUResultM = 32'h84;
                    end else begin
                        drive_idle();
                    end
                end
            end
            chk("b2b first_req_cycle", 32'(a_req), 32'd1);
            chk("b2b bus_spacing", 32'(b_req - a_req), 32'd3);
            drive_idle();
            @(posedge clk);
            #1;
        end

        // Reset while BUSY with mem_ready held low.
        MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'd2; ALUResultM = 32'h40;
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_busy mem_req_before", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        drive_idle();
        reset = 1'b1;
        #1;
        chk("rst_busy mem_req_drop", 32'(mem_req), 32'd0);
        chk("rst_busy StallM", 32'(StallM), 32'd0);
        chk("rst_busy ReadDataM", ReadDataM, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_txn(mk(1'b0, 2'b01, 3'd2, 32'h44, 32'h0, 1, 32'h11223344,
                   32'h44, 4'b0000, 32'h0, 32'h11223344, 3, 1'b0), "after_reset_lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the 5-stage RISC-V core. Consumes the execute/memory pipeline register outputs, runs a req/ready handshake to data memory, and stalls the pipeline until the access completes. It also aligns store data with byte strobes and sign- or zero-extends load data for the writeback mux.

## Interface
Parameters:
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  core clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  store request from the EX/MEM register.
- ResultSrcM  in  2  2'b01 marks a load.
- ALUResultM  in  ADDR_W  effective byte address.
- WriteDataM  in  32  store data, right-justified.
- funct3M  in  3  access size and sign.
- StallM  out  1  holds the F/D/E/M registers; combinational.
- ReadDataM  out  32  extended load result; registered.
- MisalignM  out  1  one-cycle pulse on a misaligned or illegal access; registered.
- mem_req  out  1  bus request; registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, with [1:0] = 0.
- mem_wdata  out  32  lane-aligned store data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_ready  in  1  memory completion; sampled only in BUSY.
- mem_rdata  in  32  read word; valid with mem_ready.

## Operation
- Access types:
  - load = ResultSrcM==2'b01 and MemWriteM==0.
  - store = MemWriteM==1. A store wins if both are set.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Illegal funct3, or a misaligned access: no bus request, MisalignM pulses for 1 cycle, no stall, ReadDataM unchanged.
- Store alignment: byte data is replicated to all lanes, strobe 0001<<addr[1:0]. Halfword data is replicated to both halves, strobe 0011<<addr[1:0]. Word strobe is 1111.
- Load extraction: select lane(s) by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: a legal access moves to BUSY and latches addr, we, wdata, wstrb, funct3 and addr[1:0].
  - BUSY: mem_req=1 with stable bus fields. mem_ready=1 at posedge moves to DONE; ReadDataM captures the extended mem_rdata for loads.
  - DONE: unconditionally returns to IDLE. The same instruction leaves M at the end of this cycle, so it must not re-trigger.
- StallM = (IDLE and legal access) or BUSY. It is 0 in DONE.
- Reset values: state IDLE; mem_req, mem_we, mem_wstrb, MisalignM = 0; mem_addr, mem_wdata, ReadDataM = 0.

## Timing
- A load or store issued in M at cycle 0 with mem_ready=1 on its first request cycle:
  - cycle 0: IDLE, StallM=1.
  - cycle 1: BUSY, mem_req=1, StallM=1.
  - cycle 2: DONE, StallM=0, ReadDataM valid.
- Minimum penalty is 2 stall cycles. Each wait cycle of mem_ready adds 1.
- mem_req stays high until the sampled mem_ready. It deasserts in the cycle after acceptance.
- mem_ready in IDLE or DONE is ignored.
- Back-to-back accesses: the second access is recognised in the IDLE cycle after DONE. Minimum bus spacing is 3 cycles.
- Reset asserted mid-BUSY: mem_req drops immediately (asynchronous), state goes to IDLE, and the pending access is discarded.
- MisalignM is high for exactly the cycle after detection. It is not repeated while the same instruction sits in M unless the pipeline re-presents it.

## Structure
- Package mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum IDLE/BUSY/DONE.
  - RESULTSRC_LOAD = 2'b01.
- Sub-module load_extend: combinational; inputs rdata, byte offset, funct3; output 32-bit extended data.
- Store alignment stays inline.

## Test plan
- SW 0xDEADBEEF to 0x100, ready on first request cycle -> mem_addr=0x100, mem_wstrb=1111, mem_wdata=0xDEADBEEF, StallM high for 2 cycles.
- SB 0x000000A5 to 0x203 -> mem_addr=0x200, mem_wstrb=1000, mem_wdata=0xA5A5A5A5.
- LB and LBU at 0x101 with mem_rdata=0x1234_80FF -> ReadDataM=0xFFFFFF80 and 0x00000080 respectively.
- LH at 0x102 with mem_rdata=0x8001_0000 and 3 wait cycles of mem_ready -> ReadDataM=0xFFFF8001, 5 stall cycles.
- LW at 0x102 -> no mem_req, MisalignM pulses 1 cycle, StallM stays 0.
- Reset asserted during BUSY -> mem_req=0 in the same cycle, state IDLE; a subsequent LW completes normally.
